load_store_unit: RTL and testbench

Initiator side of the data-memory port. It accepts byte-addressed RISC-V load/store requests from the MEM stage and converts them into word-indexed `MemRead`/`MemWrite` commands for the 1024-word data memory. It extracts and sign- or zero-extends sub-word loads, and performs sub-word stores as read-modify-write, because the memory is word-granular. It sits between the EX/MEM pipeline register and the data memory; its `REQ_READY` feeds the pipeline stall logic.

---
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 tb/tb_load_store_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Data-memory initiator: turns byte-addressed RISC-V loads/stores into word commands,
// extending sub-word loads and doing sub-word stores as read-modify-write.
module load_store_unit #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_IS_STORE,
  input  logic [2:0]  REQ_FUNCT3,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RESP_VALID,
  output logic [31:0] RESP_DATA,
  output logic        RESP_ERROR,
  output logic [31:0] DMEM_ADDRESS,
  output logic [31:0] DMEM_WRITE_DATA,
  output logic        DMEM_READ,
  output logic        DMEM_WRITE,
  input  logic [31:0] DMEM_READ_DATA
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOAD_WAIT = 2'd1;
  localparam logic [1:0] S_RMW       = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic [DEPTH_LOG2-1:0] widx_q, widx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            mask_q, mask_d;
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rerror_q, rerror_d;

  logic accept, illegal, misaligned, out_of_range, req_err, is_sw;

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   return f3[2] ? {24'b0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return f3[2] ? {16'b0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [31:0] new_data,
                                             input logic [3:0]  mask);
    logic [31:0] w;
    for (int k = 0; k < 4; k++)
      w[8*k +: 8] = mask[k] ? new_data[8*k +: 8] : old_word[8*k +: 8];
    return w;
  endfunction

  assign REQ_READY = (state_q == S_IDLE) && !RESET;
  assign accept    = REQ_VALID && REQ_READY;

  assign illegal = REQ_IS_STORE ? (REQ_FUNCT3[2] || (REQ_FUNCT3[1:0] == 2'b11))
                                : ((REQ_FUNCT3 == 3'b011) || (REQ_FUNCT3[2:1] == 2'b11));
  assign misaligned   = ((REQ_FUNCT3[1:0] == 2'b01) && REQ_ADDR[0]) ||
                        ((REQ_FUNCT3[1:0] == 2'b10) && (REQ_ADDR[1:0] != 2'b00));
  assign out_of_range = |REQ_ADDR[31:DEPTH_LOG2+2];
  assign req_err      = illegal || misaligned || out_of_range;
  assign is_sw        = REQ_IS_STORE && (REQ_FUNCT3 == 3'b010);

  // Memory command decode: SW writes directly, loads and sub-word stores read first
  always_comb begin
    DMEM_READ       = 1'b0;
    DMEM_WRITE      = 1'b0;
    DMEM_ADDRESS    = 32'd0;
    DMEM_WRITE_DATA = 32'd0;
    if (accept && !req_err) begin
      DMEM_ADDRESS = {{(32-DEPTH_LOG2){1'b0}}, REQ_ADDR[DEPTH_LOG2+1:2]};
      if (is_sw) begin
        DMEM_WRITE      = 1'b1;
        DMEM_WRITE_DATA = REQ_WDATA;
      end else begin
        DMEM_READ = 1'b1;
      end
    end else if ((state_q == S_RMW) && !RESET) begin
      DMEM_WRITE      = 1'b1;
      DMEM_ADDRESS    = {{(32-DEPTH_LOG2){1'b0}}, widx_q};
      DMEM_WRITE_DATA = merge_word(DMEM_READ_DATA, wdata_q, mask_q);
    end
  end

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    off_d    = off_q;
    widx_d   = widx_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    rvalid_d = 1'b0;
    rdata_d  = 32'd0;
    rerror_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err) begin
            rvalid_d = 1'b1;
            rerror_d = 1'b1;
          end else if (!REQ_IS_STORE) begin
            f3_d    = REQ_FUNCT3;
            off_d   = REQ_ADDR[1:0];
            state_d = S_LOAD_WAIT;
          end else if (is_sw) begin
            rvalid_d = 1'b1;
          end else begin
            widx_d  = REQ_ADDR[DEPTH_LOG2+1:2];
            // Replicate the store lane so the mask alone picks the target bytes
            wdata_d = REQ_FUNCT3[0] ? {2{REQ_WDATA[15:0]}} : {4{REQ_WDATA[7:0]}};
            mask_d  = REQ_FUNCT3[0] ? (REQ_ADDR[1] ? 4'b1100 : 4'b0011)
                                    : (4'b0001 << REQ_ADDR[1:0]);
            state_d = S_RMW;
          end
        end
      end
      S_LOAD_WAIT: begin
        rvalid_d = 1'b1;
        rdata_d  = load_extend(f3_q, off_q, DMEM_READ_DATA);
        state_d  = S_IDLE;
      end
      S_RMW: begin
        rvalid_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      f3_q     <= 3'd0;
      off_q    <= 2'd0;
      widx_q   <= '0;
      wdata_q  <= 32'd0;
      mask_q   <= 4'd0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      rerror_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      widx_q   <= widx_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerror_q <= rerror_d;
    end
  end

  assign RESP_VALID = rvalid_q;
  assign RESP_DATA  = rdata_q;
  assign RESP_ERROR = rerror_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random requests scored against
// a byte-array model of the data memory.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_IS_STORE;
  logic [2:0]  REQ_FUNCT3;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RESP_VALID;
  logic [31:0] RESP_DATA;
  logic        RESP_ERROR;
  logic [31:0] DMEM_ADDRESS;
  logic [31:0] DMEM_WRITE_DATA;
  logic        DMEM_READ;
  logic        DMEM_WRITE;
  logic [31:0] DMEM_READ_DATA;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  load_store_unit #(.DEPTH_LOG2(10)) dut (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_IS_STORE(REQ_IS_STORE), .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .RESP_VALID(RESP_VALID), .RESP_DATA(RESP_DATA),
    .RESP_ERROR(RESP_ERROR), .DMEM_ADDRESS(DMEM_ADDRESS),
    .DMEM_WRITE_DATA(DMEM_WRITE_DATA), .DMEM_READ(DMEM_READ),
    .DMEM_WRITE(DMEM_WRITE), .DMEM_READ_DATA(DMEM_READ_DATA)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_pat(input int idx);
    return (32'(idx) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Registered word memory; unwritten words read back their init pattern
  logic [31:0] mem [0:1023];
  bit          wr_flag [0:1023];
  always @(posedge CLK) begin
    if (DMEM_WRITE) begin
      mem[DMEM_ADDRESS[9:0]]     <= DMEM_WRITE_DATA;
      wr_flag[DMEM_ADDRESS[9:0]] <= 1'b1;
    end
    if (DMEM_READ)
      DMEM_READ_DATA <= wr_flag[DMEM_ADDRESS[9:0]] ? mem[DMEM_ADDRESS[9:0]]
                                                   : init_pat(int'(DMEM_ADDRESS[9:0]));
  end

  logic [7:0] refb [0:4095];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {refb[4*idx+3], refb[4*idx+2], refb[4*idx+1], refb[4*idx]};
  endfunction

  // Reference: error rules, byte-level store effect, assembled/extended load value
  task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output bit e, output logic [31:0] d,
                       output int lat);
    int size;
    bit ill;
    logic [63:0] v;
    ill  = st ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    size = 1 << f3[1:0];
    e    = ill || ((a % 32'(size)) != 0) || (a >= 32'd4096);
    d    = 32'd0;
    lat  = (e || (st && f3 == 3'd2)) ? 1 : 2;
    if (!e) begin
      if (st) begin
        for (int i = 0; i < size; i++) refb[int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 64'd0;
        for (int i = 0; i < size; i++) v |= 64'(refb[int'(a) + i]) << (8*i);
        if (!f3[2] && size < 4 && v[8*size-1]) v |= ~((64'd1 << (8*size)) - 64'd1);
        d = v[31:0];
      end
    end
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      chk("rw_exclusive", 32'(DMEM_READ & DMEM_WRITE), 32'd0);
      if (!DMEM_READ && !DMEM_WRITE) begin
        chk("idle_addr", DMEM_ADDRESS, 32'd0);
        chk("idle_wdata", DMEM_WRITE_DATA, 32'd0);
      end
    end
  end

  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] got);
    bit e;
    logic [31:0] d;
    int exp_lat, lat, k;
    model(st, f3, a, wd, e, d, exp_lat);
    got = 32'hx;
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_IS_STORE = st; REQ_FUNCT3 = f3; REQ_ADDR = a; REQ_WDATA = wd;
    #1;
    k = 0;
    while (!REQ_READY && k < 10) begin @(negedge CLK); #1; k++; end
    if (!REQ_READY) begin
      chk("ready_timeout", 32'(REQ_READY), 32'd1);
      REQ_VALID = 1'b0;
      return;
    end
    if (e) begin
      chk("err_no_cmd", {30'd0, DMEM_READ, DMEM_WRITE}, 32'd0);
    end else begin
      chk("cmd_addr", DMEM_ADDRESS, a >> 2);
      if (st && f3 == 3'd2) begin
        chk("sw_write", {30'd0, DMEM_READ, DMEM_WRITE}, 32'd1);
        chk("sw_wdata", DMEM_WRITE_DATA, wd);
      end else begin
        chk("read_cmd", {30'd0, DMEM_READ, DMEM_WRITE}, 32'd2);
      end
    end
    @(negedge CLK);
    REQ_VALID = 1'b0;
    chk("ready_c1", 32'(REQ_READY), 32'(exp_lat == 1));
    if (!e && st && f3 != 3'd2) begin
      chk("rmw_write", {30'd0, DMEM_READ, DMEM_WRITE}, 32'd1);
      chk("rmw_addr", DMEM_ADDRESS, a >> 2);
      chk("rmw_wdata", DMEM_WRITE_DATA, ref_word(int'(a >> 2)));
    end
    lat = 1;
    while (!RESP_VALID && lat < 5) begin @(negedge CLK); lat++; end
    chk("resp_latency", 32'(lat), 32'(exp_lat));
    chk("resp_error", 32'(RESP_ERROR), 32'(e));
    chk("resp_data", RESP_DATA, d);
    got = RESP_DATA;
  endtask

  initial begin
    logic [31:0] got, a, wd;
    bit e;
    logic [31:0] d;
    int lat;
    bit st;
    logic [2:0] f3;
    for (int w = 0; w < 1024; w++) begin
      logic [31:0] p;
      p = init_pat(w);
      for (int b = 0; b < 4; b++) refb[4*w+b] = p[8*b +: 8];
    end
    RESET = 1'b1; REQ_VALID = 1'b1; REQ_IS_STORE = 1'b1; REQ_FUNCT3 = 3'd2;
    REQ_ADDR = 32'h10; REQ_WDATA = 32'h1;
    repeat (3) @(negedge CLK);
    chk("rst_ready", 32'(REQ_READY), 32'd0);
    chk("rst_cmd", {30'd0, DMEM_READ, DMEM_WRITE}, 32'd0);
    REQ_VALID = 1'b0;
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_resp_valid", 32'(RESP_VALID), 32'd0);
    chk("rst_resp_data", RESP_DATA, 32'd0);
    chk("rst_resp_error", 32'(RESP_ERROR), 32'd0);
    chk("post_rst_ready", 32'(REQ_READY), 32'd1);
    mon_en = 1'b1;

    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, got);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, got);
    chk("lw_deadbeef", got, 32'hDEADBEEF);
    do_req(1'b0, 3'd0, 32'h13, 32'h0, got);
    chk("lb_13", got, 32'hFFFFFFDE);
    do_req(1'b0, 3'd4, 32'h13, 32'h0, got);
    chk("lbu_13", got, 32'h000000DE);
    do_req(1'b0, 3'd1, 32'h10, 32'h0, got);
    chk("lh_10", got, 32'hFFFFBEEF);
    do_req(1'b0, 3'd5, 32'h12, 32'h0, got);
    chk("lhu_12", got, 32'h0000DEAD);
    do_req(1'b1, 3'd0, 32'h11, 32'h55, got);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, got);
    chk("sb_word", got, 32'hDEAD55EF);
    do_req(1'b1, 3'd1, 32'h12, 32'h1234, got);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, got);
    chk("sh_word", got, 32'h123455EF);
    do_req(1'b0, 3'd2, 32'h12, 32'h0, got);
    do_req(1'b1, 3'd1, 32'h13, 32'h0, got);
    do_req(1'b0, 3'd3, 32'h10, 32'h0, got);
    do_req(1'b0, 3'd2, 32'h1000, 32'h0, got);
    do_req(1'b1, 3'd3, 32'h10, 32'h0, got);

    // Reset lands in the RMW cycle: the write and its response must vanish
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_IS_STORE = 1'b1; REQ_FUNCT3 = 3'd0; REQ_ADDR = 32'h30;
    REQ_WDATA = 32'hA5;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    RESET = 1'b1;
    #1;
    chk("rst_rmw_no_write", 32'(DMEM_WRITE), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("rst_rmw_no_resp", 32'(RESP_VALID), 32'd0);
    chk("rst_rmw_ready", 32'(REQ_READY), 32'd1);
    do_req(1'b0, 3'd2, 32'h30, 32'h0, got);

    // Back-to-back SW, SW, LW with valid held
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_IS_STORE = 1'b1; REQ_FUNCT3 = 3'd2; REQ_ADDR = 32'h20;
    REQ_WDATA = 32'hCAFEF00D;
    model(1'b1, 3'd2, 32'h20, 32'hCAFEF00D, e, d, lat);
    chk("b2b_ready_c", 32'(REQ_READY), 32'd1);
    @(negedge CLK);
    REQ_ADDR = 32'h24; REQ_WDATA = 32'h0BADF00D;
    model(1'b1, 3'd2, 32'h24, 32'h0BADF00D, e, d, lat);
    chk("b2b_ready_c1", 32'(REQ_READY), 32'd1);
    chk("b2b_resp_c1", 32'(RESP_VALID), 32'd1);
    @(negedge CLK);
    REQ_IS_STORE = 1'b0; REQ_ADDR = 32'h20;
    chk("b2b_ready_c2", 32'(REQ_READY), 32'd1);
    chk("b2b_resp_c2", 32'(RESP_VALID), 32'd1);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    chk("b2b_ready_c3", 32'(REQ_READY), 32'd0);
    chk("b2b_noresp_c3", 32'(RESP_VALID), 32'd0);
    @(negedge CLK);
    chk("b2b_resp_c4", 32'(RESP_VALID), 32'd1);
    chk("b2b_lw_data", RESP_DATA, 32'hCAFEF00D);
    do_req(1'b0, 3'd2, 32'h24, 32'h0, got);

    for (int n = 0; n < 200; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63));
      wd = $urandom;
      do_req(st, f3, a, wd, got);
    end

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
